lfsr_bert_ctrl: RTL and testbench

Bit-error-rate test controller for 32-bit LFSR pattern streams, such as those produced by the team's LFSR generator. It sits downstream of a link or DUT loopback and consumes the received AXI-Stream words. It self-seeds a local predictor, acquires lock after a run of consecutive matching words, then counts words, errored words and errored bits over a programmed test length. The polynomial is selected by index from the shared LFSR_poly polynomial table.

---
 rtl/lfsr_bert_ctrl.sv | 125 ++++++++++++
 tb/tb_lfsr_bert_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_bert_ctrl.sv
// lfsr_bert_ctrl: BER checker that self-seeds, locks onto and counts errors in a 32-bit LFSR stream
package LFSR_poly;
  localparam logic [31:0] polynomials [4] = '{32'h80000057, 32'h80000062, 32'h80200003, 32'hA3000000};
endpackage

module lfsr_bert_ctrl #(
  parameter int POLY_INDEX   = 0,
  parameter int LOCK_MATCHES = 16,
  parameter int UNLOCK_ERRS  = 8
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] num_words,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  output logic        busy,
  output logic        locked,
  output logic        done,
  output logic [31:0] word_count,
  output logic [31:0] word_err_count,
  output logic [31:0] bit_err_count,
  output logic [2:0]  state
);
  localparam logic [2:0] S_IDLE = 3'd0, S_ACQ = 3'd1, S_LOCK = 3'd2, S_RUN = 3'd3, S_DONE = 3'd4;
  localparam logic [31:0] POLY = LFSR_poly::polynomials[POLY_INDEX];
  localparam logic [7:0] LM = 8'(LOCK_MATCHES);
  localparam logic [7:0] UE = 8'(UNLOCK_ERRS);

  function automatic logic [31:0] step(input logic [31:0] w);
    return {w[30:0], ^(w & POLY)};
  endfunction

  logic [31:0] expected, nw_q, exp_n, nw_n, wc_n, wec_n, bec_n, diff;
  logic [7:0]  match_run, err_run, mr_n, er_n;
  logic [2:0]  state_n;
  logic [5:0]  pop;
  logic [32:0] bit_sum;
  logic        hit, miss;

  assign S_AXIS_TREADY = 1'b1;
  assign diff    = S_AXIS_TDATA ^ expected;
  assign hit     = diff == '0;
  assign miss    = !hit;
  assign pop     = 6'($countones(diff));
  assign bit_sum = {1'b0, bit_err_count} + {27'd0, pop};

  always_comb begin
    state_n = state;
    exp_n   = expected;
    mr_n    = match_run;
    er_n    = err_run;
    wc_n    = word_count;
    wec_n   = word_err_count;
    bec_n   = bit_err_count;
    nw_n    = nw_q;
    if (abort) state_n = S_IDLE;
    else if (start && !busy) begin
      state_n = S_ACQ;
      wc_n    = '0;
      wec_n   = '0;
      bec_n   = '0;
      nw_n    = num_words;
    end else if (S_AXIS_TVALID) begin
      case (state)
        S_ACQ: begin
          exp_n   = step(S_AXIS_TDATA);
          mr_n    = '0;
          state_n = S_LOCK;
        end
        S_LOCK: begin
          exp_n = step(S_AXIS_TDATA);
          mr_n  = hit ? match_run + 8'd1 : '0;
          if (hit && mr_n == LM) begin
            state_n = S_RUN;
            er_n    = '0;
          end
        end
        S_RUN: begin
          wc_n  = word_count + 32'd1;
          bec_n = bit_sum[32] ? '1 : bit_sum[31:0];
          wec_n = (miss && !(&word_err_count)) ? word_err_count + 32'd1 : word_err_count;
          er_n  = miss ? err_run + 8'd1 : '0;
          // predictor free-runs so a single corrupted word is counted once
          exp_n = step(expected);
          if (miss && er_n == UE) begin
            state_n = S_LOCK;
            exp_n   = step(S_AXIS_TDATA);
            mr_n    = '0;
          end else if (nw_q != '0 && wc_n == nw_q) state_n = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      locked         <= 1'b0;
      done           <= 1'b0;
      word_count     <= '0;
      word_err_count <= '0;
      bit_err_count  <= '0;
      expected       <= '1;
      match_run      <= '0;
      err_run        <= '0;
      nw_q           <= '0;
    end else begin
      state          <= state_n;
      busy           <= state_n == S_ACQ || state_n == S_LOCK || state_n == S_RUN;
      locked         <= state_n == S_RUN;
      done           <= state_n == S_DONE;
      word_count     <= wc_n;
      word_err_count <= wec_n;
      bit_err_count  <= bec_n;
      expected       <= exp_n;
      match_run      <= mr_n;
      err_run        <= er_n;
      nw_q           <= nw_n;
    end
endmodule

// File: tb/tb_lfsr_bert_ctrl.sv
// tb_lfsr_bert_ctrl: scoreboarded directed and random check of lfsr_bert_ctrl against a spec-level model
module tb_lfsr_bert_ctrl;
  localparam logic [31:0] POLY = 32'h80000057;
  localparam int LM = 16, UE = 8;

  logic clk = 0, aresetn = 0, start = 0, abort = 0, S_AXIS_TVALID = 0;
  logic S_AXIS_TREADY, busy, locked, done;
  logic [31:0] num_words = 0, S_AXIS_TDATA = 0, word_count, word_err_count, bit_err_count;
  logic [2:0] state;

  always #5 clk = ~clk;

  lfsr_bert_ctrl #(.POLY_INDEX(0), .LOCK_MATCHES(LM), .UNLOCK_ERRS(UE)) dut (
    .clk(clk), .aresetn(aresetn), .start(start), .abort(abort), .num_words(num_words),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .busy(busy), .locked(locked), .done(done), .word_count(word_count),
    .word_err_count(word_err_count), .bit_err_count(bit_err_count), .state(state)
  );

  typedef struct { int st; logic [31:0] wc, wec, bec; } exp_t;
  exp_t sb[$];
  exp_t e;
  int vectors = 0, miscompares = 0;
  bit tready_bad = 0;

  int m_st, m_mr, m_er;
  logic [31:0] m_exp, m_wc, m_nw, tx;
  longint m_wec, m_bec;

  function automatic logic [31:0] ref_next(input logic [31:0] w);
    int n = 0;
    for (int i = 0; i < 32; i++) if (w[i] && POLY[i]) n++;
    return (w << 1) | 32'(n % 2);
  endfunction

  function automatic int ones(input logic [31:0] w);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(w[i]);
    return n;
  endfunction

  task automatic model_reset();
    m_st = 0; m_mr = 0; m_er = 0; m_exp = '1; m_wc = 0; m_nw = 0; m_wec = 0; m_bec = 0;
  endtask

  task automatic model(input bit v, input logic [31:0] d, input bit s, input logic [31:0] nw, input bit a);
    logic [31:0] df;
    if (a) begin m_st = 0; return; end
    if (s && (m_st == 0 || m_st == 4)) begin
      m_st = 1; m_wc = 0; m_wec = 0; m_bec = 0; m_nw = nw;
      return;
    end
    if (!v) return;
    if (m_st == 1) begin
      m_exp = ref_next(d); m_mr = 0; m_st = 2;
    end else if (m_st == 2) begin
      if (d == m_exp) begin
        m_mr++;
        if (m_mr == LM) begin m_st = 3; m_er = 0; end
      end else m_mr = 0;
      m_exp = ref_next(d);
    end else if (m_st == 3) begin
      df = d ^ m_exp;
      m_wc = m_wc + 1;
      m_bec = m_bec + ones(df);
      if (m_bec > 64'hFFFFFFFF) m_bec = 64'hFFFFFFFF;
      if (df != 0) begin
        if (m_wec < 64'hFFFFFFFF) m_wec++;
        m_er++;
      end else m_er = 0;
      m_exp = ref_next(m_exp);
      if (df != 0 && m_er == UE) begin
        m_st = 2; m_exp = ref_next(d); m_mr = 0;
      end else if (m_nw != 0 && m_wc == m_nw) m_st = 4;
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit s, input logic [31:0] nw, input bit a);
    exp_t r;
    @(negedge clk);
    S_AXIS_TVALID = v; S_AXIS_TDATA = d; start = s; num_words = nw; abort = a;
    model(v, d, s, nw, a);
    if (v || s || a) begin
      r.st = m_st; r.wc = m_wc; r.wec = 32'(m_wec); r.bec = 32'(m_bec);
      sb.push_back(r);
    end
  endtask

  task automatic idle();
    drive(0, $urandom, 0, 0, 0);
  endtask

  task automatic beat(input logic [31:0] flip);
    drive(1, tx ^ flip, 0, 0, 0);
    tx = ref_next(tx);
  endtask

  task automatic go(input logic [31:0] nw);
    drive(0, 0, 1, nw, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic timeout(input string name);
    vectors++; miscompares++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  task automatic run_to_done(input int bound, input int pv);
    int n = 0;
    while (m_st != 4 && n < bound) begin
      if ($urandom_range(99) < pv) beat(0); else idle();
      n++;
    end
    if (m_st != 4) timeout("run_to_done");
  endtask

  always @(negedge clk) if (S_AXIS_TREADY !== 1'b1) tready_bad = 1;

  always @(posedge clk)
    if (aresetn && (S_AXIS_TVALID || start || abort)) begin
      #1;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard: DUT event at %0t with no expectation", $time);
      end else begin
        e = sb.pop_front();
        if (state !== 3'(e.st) || locked !== (e.st == 3) || busy !== (e.st >= 1 && e.st <= 3) ||
            done !== (e.st == 4) || word_count !== e.wc || word_err_count !== e.wec || bit_err_count !== e.bec) begin
          miscompares++;
          $display("FAIL beat t=%0t: got st=%0d lk=%b bz=%b dn=%b wc=%0d wec=%0d bec=%0d, want st=%0d wc=%0d wec=%0d bec=%0d",
                   $time, state, locked, busy, done, word_count, word_err_count, bit_err_count, e.st, e.wc, e.wec, e.bec);
        end
      end
    end

  initial begin
    int n, idx;
    logic [31:0] nw;
    model_reset();
    #12;
    chk("rst_state", state, 0); chk("rst_busy", busy, 0); chk("rst_locked", locked, 0);
    chk("rst_done", done, 0); chk("rst_wc", word_count, 0); chk("rst_wec", word_err_count, 0);
    chk("rst_bec", bit_err_count, 0);
    @(negedge clk) aresetn = 1;

    tx = '1; go(100);
    repeat (16) beat(0);
    idle(); chk("lock_b16", locked, 0);
    beat(0);
    idle(); chk("lock_b17", locked, 1);
    run_to_done(200, 100);
    idle(); chk("s1_done", done, 1); chk("s1_wc", word_count, 100);
    chk("s1_wec", word_err_count, 0); chk("s1_bec", bit_err_count, 0); chk("s1_locked", locked, 0);

    tx = '1; go(100); n = 0;
    while (m_st != 4 && n < 300) begin
      idx = (m_st == 3) ? int'(m_wc) + 1 : 0;
      beat(idx == 10 ? 32'h21 : idx == 50 ? 32'h80000000 : 32'h0);
      n++;
    end
    if (m_st != 4) timeout("s2");
    idle(); chk("s2_wc", word_count, 100); chk("s2_wec", word_err_count, 2); chk("s2_bec", bit_err_count, 3);

    tx = '1; go(0); n = 0;
    while (!(m_st == 3 && m_wc == 5) && n < 100) begin beat(0); n++; end
    repeat (8) beat($urandom | 32'h1);
    idle(); chk("unlock_state", state, 2); chk("unlock_locked", locked, 0); chk("unlock_wc", word_count, 13);
    n = 0;
    while (m_st != 3 && n < 60) begin beat(0); n++; end
    if (m_st != 3) timeout("relock");
    repeat (5) beat(0);
    idle(); chk("relock_wc", word_count, 18); chk("relock_wec", word_err_count, 8);
    drive(0, 0, 0, 0, 1);

    tx = '1; go(20); beat(0);
    repeat (10) beat(0);
    beat(32'h4);
    run_to_done(100, 100);
    idle(); chk("s4_wc", word_count, 20); chk("s4_wec", word_err_count, 0);

    tx = '1; go(100);
    run_to_done(800, 50);
    idle(); chk("s5_done", done, 1); chk("s5_wc", word_count, 100);
    chk("s5_wec", word_err_count, 0); chk("s5_bec", bit_err_count, 0);

    tx = '1; go(0); n = 0;
    while (!(m_st == 3 && m_wc == 20) && n < 100) begin beat(0); n++; end
    drive(1, tx, 1, 5, 0); tx = ref_next(tx);
    n = 0;
    while (m_wc != 40 && n < 100) begin beat(0); n++; end
    drive(1, tx, 0, 0, 1);
    idle(); chk("abort_state", state, 0); chk("abort_wc", word_count, 40);
    chk("abort_busy", busy, 0); chk("abort_locked", locked, 0);
    go(7);
    idle(); chk("restart_wc", word_count, 0); chk("restart_state", state, 1);
    run_to_done(200, 100);
    idle(); chk("restart_done_wc", word_count, 7);

    go(0);
    repeat (25) beat(0);
    @(negedge clk);
    S_AXIS_TVALID = 0; aresetn = 0;
    #1 chk("mid_rst_state", state, 0); chk("mid_rst_wc", word_count, 0); chk("mid_rst_locked", locked, 0);
    model_reset();
    @(negedge clk) aresetn = 1;

    repeat (6) begin
      tx = $urandom; nw = $urandom_range(1, 60);
      go(nw); n = 0;
      while (m_st != 4 && n < 800) begin
        if ($urandom_range(99) < 70) beat($urandom_range(99) < 5 ? $urandom : 32'h0); else idle();
        n++;
      end
      if (m_st != 4) drive(0, 0, 0, 0, 1);
    end

    repeat (3) idle();
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain: %0d left, want 0", sb.size()); end
    vectors++;
    if (tready_bad) begin miscompares++; $display("FAIL tready: got 0 on some cycle, want 1"); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
